matmul_stream_engine: RTL and testbench

//   Streaming, sequential NxN matrix multiplier: C = A x B, unsigned, modulo 2^DATA_W.

---
 rtl/matmul_stream_engine.sv | 148 ++++++++++++++
 tb/tb_matmul_stream_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_engine.sv
// Streaming NxN unsigned matrix multiplier (C = A x B mod 2^DATA_W).
// Operands arrive as a row-major stream; one MAC per cycle; C leaves row-major.
module matmul_stream_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned NN    = N * N;
    localparam int unsigned CNT_W = $clog2(2 * NN);
    localparam int unsigned AW    = $clog2(NN);
    localparam int unsigned IW    = $clog2(N);

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  ld_cnt;
    logic [IW-1:0]     i;
    logic [IW-1:0]     j;
    logic [IW-1:0]     k;
    logic [DATA_W-1:0] acc;
    logic [AW-1:0]     drain_cnt;

    logic [DATA_W-1:0] a_mem [NN];
    logic [DATA_W-1:0] b_mem [NN];
    logic [DATA_W-1:0] c_mem [NN];

    logic              load_beat_c;
    logic              ld_last_c;
    logic              k_last_c;
    logic              mac_last_c;
    logic              out_fire_c;
    logic [AW-1:0]     a_addr_c;
    logic [AW-1:0]     b_addr_c;
    logic [AW-1:0]     c_addr_c;
    logic [AW-1:0]     drain_next_c;
    logic [DATA_W-1:0] prod_c;
    logic [DATA_W-1:0] acc_next_c;

    assign load_beat_c  = (state == S_LOAD) && in_valid && in_ready;
    assign ld_last_c    = (ld_cnt == CNT_W'(2 * NN - 1));
    assign k_last_c     = (k == IW'(N - 1));
    assign mac_last_c   = k_last_c && (j == IW'(N - 1)) && (i == IW'(N - 1));
    assign out_fire_c   = out_valid && out_ready;
    assign a_addr_c     = AW'(i) * AW'(N) + AW'(k);
    assign b_addr_c     = AW'(k) * AW'(N) + AW'(j);
    assign c_addr_c     = AW'(i) * AW'(N) + AW'(j);
    assign drain_next_c = drain_cnt + AW'(1);

    // Single MAC; the product and the sum both wrap at DATA_W bits.
    assign prod_c     = a_mem[a_addr_c] * b_mem[b_addr_c];
    assign acc_next_c = ((k == '0) ? '0 : acc) + prod_c;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:    if (load_beat_c && ld_last_c) state_next = S_COMPUTE;
            S_COMPUTE: if (mac_last_c) state_next = S_DRAIN;
            S_DRAIN:   if (out_fire_c && out_last) state_next = S_LOAD;
            default:   state_next = S_LOAD;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            ld_cnt    <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            drain_cnt <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == S_LOAD);
            busy     <= (state_next != S_LOAD);
            case (state)
                S_LOAD: begin
                    if (load_beat_c) ld_cnt <= ld_last_c ? '0 : ld_cnt + CNT_W'(1);
                end
                S_COMPUTE: begin
                    acc <= acc_next_c;
                    if (k_last_c) begin
                        k <= '0;
                        if (j == IW'(N - 1)) begin
                            j <= '0;
                            i <= (i == IW'(N - 1)) ? '0 : i + IW'(1);
                        end else begin
                            j <= j + IW'(1);
                        end
                    end else begin
                        k <= k + IW'(1);
                    end
                end
                S_DRAIN: begin
                    // Entry cycle presents C[0][0]; afterwards advance only on accept.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= c_mem[0];
                        out_last  <= 1'b0;
                        drain_cnt <= '0;
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            drain_cnt <= '0;
                        end else begin
                            out_data  <= c_mem[drain_next_c];
                            out_last  <= (drain_next_c == AW'(NN - 1));
                            drain_cnt <= drain_next_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and result storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (load_beat_c) begin
            if (ld_cnt < CNT_W'(NN)) a_mem[AW'(ld_cnt)] <= in_data;
            else                     b_mem[AW'(ld_cnt - CNT_W'(NN))] <= in_data;
        end
        if ((state == S_COMPUTE) && k_last_c) c_mem[c_addr_c] <= acc_next_c;
    end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Bench for matmul_stream_engine: constant and random vectors against a plain
// triple-loop matrix product, plus reset-abort sequences.
module tb_matmul_stream_engine;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 3;
    localparam int unsigned NN = N * N;
    localparam int LATENCY = N * N * N + 1;

    typedef logic [NN-1:0][DW-1:0] mat_t;
    typedef struct packed {
        mat_t       a;
        mat_t       b;
        mat_t       c;
        logic [7:0] gap_pct;
        logic [7:0] rdy_pct;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_edge = 0;

    matmul_stream_engine #(.DATA_W(DW), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mat_t matmul(input mat_t a, input mat_t b);
        mat_t c;
        logic [DW-1:0] s;
        for (int r = 0; r < N; r++)
            for (int q = 0; q < N; q++) begin
                s = '0;
                for (int m = 0; m < N; m++) s = s + a[r*N+m] * b[m*N+q];
                c[r*N+q] = s;
            end
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Feed the first nbeats of A then B, with optional random in_valid gaps.
    task automatic load(input mat_t a, input mat_t b, input int nbeats, input int gap_pct);
        int kk = 0;
        int budget = 0;
        logic v;
        while (kk < nbeats && budget < 2000) begin
            @(negedge clk);
            budget++;
            check("load_in_ready", 64'(in_ready), 64'(1));
            check("load_busy", 64'(busy), 64'(0));
            v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = (kk < NN) ? a[kk] : b[kk-NN];
            if (v && in_ready) begin
                if (kk == 2 * NN - 1) last_edge = cyc + 1;
                kk++;
            end
        end
        if (kk < nbeats) check("load_timeout", 64'(kk), 64'(nbeats));
    endtask

    // Collect N*N results under random backpressure, checking order, hold and latency.
    task automatic drain(input mat_t exp_c, input int rdy_pct, input string tag);
        int idx = 0;
        int budget = 0;
        bit seen = 0;
        bit prev_stall = 0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic rdy;
        while (idx < NN && budget < 3000) begin
            @(negedge clk);
            budget++;
            in_valid = 1'($urandom_range(1));
            in_data  = $urandom;
            check({tag, "_in_ready_low"}, 64'(in_ready), 64'(0));
            check({tag, "_busy"}, 64'(busy), 64'(1));
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
                check({tag, "_hold_data"}, 64'(out_data), 64'(prev_data));
                check({tag, "_hold_last"}, 64'(out_last), 64'(prev_last));
            end
            if (out_valid && !seen) begin
                seen = 1;
                check({tag, "_latency"}, 64'(cyc - last_edge), 64'(LATENCY));
            end
            if (out_valid) begin
                check({tag, "_data"}, 64'(out_data), 64'(exp_c[idx]));
                check({tag, "_last"}, 64'(out_last), 64'(idx == NN - 1));
            end
            rdy = ($urandom_range(99) < rdy_pct);
            out_ready  = rdy;
            prev_stall = out_valid && !rdy;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && rdy) idx++;
        end
        if (idx < NN) check({tag, "_drain_timeout"}, 64'(idx), 64'(NN));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_post_busy"}, 64'(busy), 64'(0));
    endtask

    int a2[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int b2[9]  = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int c2[9]  = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int b1[9]  = '{2, 3, 4, 1, 0, 6, 7, 5, 1};

    vec_t tbl [9];
    mat_t ident, two_i, junk_a, junk_b;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        ident = '0; two_i = '0;
        for (int r = 0; r < N; r++) begin
            ident[r*N+r] = 32'd1;
            two_i[r*N+r] = 32'd2;
        end
        // Directed vectors with hand-derived results
        tbl[0].a = ident; tbl[0].gap_pct = 8'd0;  tbl[0].rdy_pct = 8'd100;
        for (int e = 0; e < NN; e++) begin
            tbl[0].b[e] = DW'(b1[e]);
            tbl[0].c[e] = DW'(b1[e]);
            tbl[1].a[e] = DW'(a2[e]);
            tbl[1].b[e] = DW'(b2[e]);
            tbl[1].c[e] = DW'(c2[e]);
        end
        tbl[1].gap_pct = 8'd0; tbl[1].rdy_pct = 8'd100;
        tbl[2] = tbl[1]; tbl[2].gap_pct = 8'd40; tbl[2].rdy_pct = 8'd50;
        tbl[3].a = '0; tbl[3].a[0] = 32'hFFFF_FFFF; tbl[3].b = two_i;
        tbl[3].c = '0; tbl[3].c[0] = 32'hFFFF_FFFE;
        tbl[3].gap_pct = 8'd20; tbl[3].rdy_pct = 8'd70;
        // Random vectors, expectations from the reference product
        for (int t = 4; t < 9; t++) begin
            for (int e = 0; e < NN; e++) begin
                tbl[t].a[e] = (t < 6) ? DW'($urandom_range(255)) : $urandom;
                tbl[t].b[e] = (t < 6) ? DW'($urandom_range(255)) : $urandom;
            end
            tbl[t].c = matmul(tbl[t].a, tbl[t].b);
            tbl[t].gap_pct = 8'($urandom_range(50));
            tbl[t].rdy_pct = 8'($urandom_range(30, 90));
        end

        do_reset();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));

        for (int t = 0; t < 9; t++) begin
            load(tbl[t].a, tbl[t].b, 2 * NN, int'(tbl[t].gap_pct));
            drain(tbl[t].c, int'(tbl[t].rdy_pct), $sformatf("vec%0d", t));
        end

        // Abort a load after 10 beats; the next stream must start again at A[0][0]
        for (int e = 0; e < NN; e++) begin
            junk_a[e] = $urandom | 32'h100;
            junk_b[e] = $urandom | 32'h100;
        end
        load(junk_a, junk_b, 10, 0);
        @(negedge clk);
        in_valid = 1'b0;
        do_reset();
        load(tbl[1].a, tbl[1].b, 2 * NN, 0);
        drain(tbl[1].c, 100, "abort_load");

        // Reset while results are being drained
        load(tbl[1].a, tbl[1].b, 2 * NN, 0);
        begin
            int w = 0;
            while (!out_valid && w < 200) begin
                @(negedge clk);
                in_valid = 1'b0;
                w++;
            end
            check("wait_drain_valid", 64'(out_valid), 64'(1));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("drain_rst_valid", 64'(out_valid), 64'(0));
        check("drain_rst_in_ready", 64'(in_ready), 64'(1));
        check("drain_rst_busy", 64'(busy), 64'(0));
        check("drain_rst_data", 64'(out_data), 64'(0));
        load(tbl[0].a, tbl[0].b, 2 * NN, 10);
        drain(tbl[0].c, 60, "after_drain_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
